// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared types, codec register sub-addresses and the configuration table
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_DONE,
    S_ERROR,
    S_REFRESH
  } cfg_state_e;

  localparam logic [7:0] DEV_ADDR_DEF = 8'h34;

  // Sub-address bytes are the codec register number shifted left by one.
  localparam logic [7:0] SA_LLINE  = 8'h00;
  localparam logic [7:0] SA_RLINE  = 8'h02;
  localparam logic [7:0] SA_LHP    = 8'h04;
  localparam logic [7:0] SA_RHP    = 8'h06;
  localparam logic [7:0] SA_APATH  = 8'h08;
  localparam logic [7:0] SA_DPATH  = 8'h0A;
  localparam logic [7:0] SA_IFACE  = 8'h0E;
  localparam logic [7:0] SA_SRATE  = 8'h10;
  localparam logic [7:0] SA_ACTIVE = 8'h12;

  localparam int unsigned IDX_MIC = 3;
  localparam int unsigned IDX_LHP = 7;
  localparam int unsigned IDX_RHP = 8;

  function automatic logic [15:0] cfg_word(input int unsigned idx, input logic mic_on,
                                           input logic [6:0] hp_vol);
    logic [15:0] w;
    case (idx)
      2:       w = {SA_IFACE, 8'h42};
      3:       w = {SA_APATH, (mic_on ? 8'h15 : 8'h10)};
      4:       w = {SA_SRATE, 8'h00};
      5:       w = {SA_LLINE, 8'h7F};
      6:       w = {SA_RLINE, 8'h7F};
      7:       w = {SA_LHP, 1'b1, hp_vol};
      8:       w = {SA_RHP, 1'b0, hp_vol};
      9:       w = {SA_DPATH, 8'h01};
      default: w = {SA_ACTIVE, 8'h01};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cfg_phase_gen.sv
// rtl/cfg_phase_gen.sv - bit-period counter, SCL/SDA window levels, rising-edge ticks and AUD_XCK
module cfg_phase_gen #(
  parameter int DIV     = 2048,
  parameter int SCL_ON  = 800,
  parameter int SCL_OFF = 1820,
  parameter int SDA_ON  = 450,
  parameter int SDA_OFF = 1990,
  parameter int XCK_BIT = 1
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  output logic scl_level,
  output logic scl_tick,
  output logic sda_tick,
  output logic aud_xck
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          scl_level_q, scl_level_d;
  logic          sda_level_q, sda_level_d;
  logic          scl_tick_q, scl_tick_d;
  logic          sda_tick_q, sda_tick_d;

  always_comb begin
    // DIV is a power of two, so the natural wrap of the counter is the period.
    cnt_d       = cnt_q + 1'b1;
    scl_level_d = (cnt_q >= CW'(SCL_ON)) && (cnt_q < CW'(SCL_OFF));
    sda_level_d = (cnt_q >= CW'(SDA_ON)) && (cnt_q < CW'(SDA_OFF));
    scl_tick_d  = scl_level_d && !scl_level_q;
    sda_tick_d  = sda_level_d && !sda_level_q;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      scl_level_q <= 1'b0;
      sda_level_q <= 1'b0;
      scl_tick_q  <= 1'b0;
      sda_tick_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      scl_level_q <= scl_level_d;
      sda_level_q <= sda_level_d;
      scl_tick_q  <= scl_tick_d;
      sda_tick_q  <= sda_tick_d;
    end
  end

  assign scl_level = scl_level_q;
  assign scl_tick  = scl_tick_q;
  assign sda_tick  = sda_tick_q;
  assign aud_xck   = cnt_q[XCK_BIT];

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - walks the codec register table over I2C with retry and incremental refresh
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         DIV       = 2048,
  parameter int         SCL_ON    = 800,
  parameter int         SCL_OFF   = 1820,
  parameter int         SDA_ON    = 450,
  parameter int         SDA_OFF   = 1990,
  parameter int         XCK_BIT   = 1,
  parameter int         N_WORDS   = 10,
  parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         MAX_RETRY = 3
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mic_on,
  input  logic [6:0]  hp_vol,
  input  logic        next_word,
  input  logic        ack_ok,
  output logic [23:0] data,
  output logic        transaction_req,
  output logic        scl_level,
  output logic        scl_tick,
  output logic        sda_tick,
  output logic        aud_xck,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mic_led
);

  localparam int IW = $clog2(N_WORDS);
  localparam int RW = $clog2(MAX_RETRY + 1);

  cfg_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          refr_q, refr_d;
  logic          pend_mic_q, pend_mic_d;
  logic          pend_vol_q, pend_vol_d;
  logic          mic_q, mic_d;
  logic [6:0]    vol_q, vol_d;
  logic [23:0]   data_q, data_d;
  logic [15:0]   word;
  logic          clr_mic, clr_vol;

  cfg_phase_gen #(
    .DIV(DIV), .SCL_ON(SCL_ON), .SCL_OFF(SCL_OFF),
    .SDA_ON(SDA_ON), .SDA_OFF(SDA_OFF), .XCK_BIT(XCK_BIT)
  ) u_phase (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .scl_level(scl_level),
    .scl_tick (scl_tick),
    .sda_tick (sda_tick),
    .aud_xck  (aud_xck)
  );

  always_comb begin
    word    = cfg_word(32'(idx_q), mic_on, hp_vol);
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    refr_d  = refr_q;
    data_d  = data_q;
    clr_mic = 1'b0;
    clr_vol = 1'b0;
    mic_d   = mic_on;
    vol_d   = hp_vol;

    case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d  = {DEV_ADDR, word};
        clr_mic = (idx_q == IW'(IDX_MIC));
        // The volume pair is covered from its first word so a change mid-pair resends both.
        clr_vol = (idx_q == IW'(IDX_LHP));
        state_d = S_REQ;
      end
      S_REQ: begin
        if (next_word) begin
          if (ack_ok) begin
            retry_d = '0;
            if (refr_q) begin
              if (idx_q == IW'(IDX_LHP)) begin
                idx_d   = IW'(IDX_RHP);
                state_d = S_LOAD;
              end else begin
                state_d = S_REFRESH;
              end
            end else if (idx_q == IW'(N_WORDS - 1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_LOAD;
            end
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RW'(MAX_RETRY)) ? S_ERROR : S_LOAD;
          end
        end
      end
      S_DONE: begin
        if (pend_mic_q || pend_vol_q) state_d = S_REFRESH;
      end
      S_REFRESH: begin
        refr_d = 1'b1;
        if (pend_mic_q) begin
          idx_d   = IW'(IDX_MIC);
          state_d = S_LOAD;
        end else if (pend_vol_q) begin
          idx_d   = IW'(IDX_LHP);
          state_d = S_LOAD;
        end else begin
          refr_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_LOAD;
      idx_d   = '0;
      retry_d = '0;
      refr_d  = 1'b0;
    end

    // A change arriving in the same cycle as the clear wins, so the new value is re-sent.
    pend_mic_d = !start && ((mic_on != mic_q) || (pend_mic_q && !clr_mic));
    pend_vol_d = !start && ((hp_vol != vol_q) || (pend_vol_q && !clr_vol));
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      refr_q     <= 1'b0;
      pend_mic_q <= 1'b0;
      pend_vol_q <= 1'b0;
      mic_q      <= 1'b0;
      vol_q      <= '0;
      data_q     <= {DEV_ADDR, 16'h0000};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      refr_q     <= refr_d;
      pend_mic_q <= pend_mic_d;
      pend_vol_q <= pend_vol_d;
      mic_q      <= mic_d;
      vol_q      <= vol_d;
      data_q     <= data_d;
    end
  end

  assign data            = data_q;
  assign transaction_req = (state_q == S_REQ);
  assign busy            = (state_q == S_LOAD) || (state_q == S_REQ) || (state_q == S_REFRESH);
  assign done            = (state_q == S_DONE);
  assign error           = (state_q == S_ERROR);
  assign mic_led         = mic_q;

endmodule
